// File: rtl/core_bus_pkg.sv
// Shared encodings for the core bus bridge and its UART transmitter.
// Defining CORE_BUS_PARITY_EN adds the PARITY state to the transmitter encoding.
package core_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef CORE_BUS_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } tx_state_t;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [19:0] DEFAULT_IO_BASE = 20'hFFFF0;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/core_bus_fifo.sv
// Synchronous transmit FIFO; a push and a pop in the same cycle both succeed
// even when full or empty (an empty FIFO forwards the pushed byte to the head).
module core_bus_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Status flags, accepted push/pop and head selection
    always_comb begin
        o_full    = (r_count == FULL_CNT);
        o_empty   = (r_count == {(AW+1){1'b0}});
        o_count   = r_count;
        w_do_push = i_push & (~o_full | i_pop);
        w_do_pop  = i_pop & (~o_empty | i_push);
        if (o_empty) begin
            o_head = i_push_data;
        end else begin
            o_head = r_mem[r_rd];
        end
    end

    // Storage write; payload needs no reset
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr    <= {AW{1'b0}};
            r_rd    <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd <= r_rd + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/core_bus.sv
// Core bus bridge: RAM pass-through plus a 2-byte I/O window feeding a UART transmitter.
// Defining CORE_BUS_PARITY_EN sends an even-parity bit between the data bits and STOP.
module core_bus
    import core_bus_pkg::*;
#(
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [19:0] IO_BASE    = DEFAULT_IO_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  wdata,
    input  logic        wren,
    output logic [7:0]  rdata,
    output logic [19:0] ram_address,
    output logic [7:0]  ram_wdata,
    output logic        ram_wren,
    input  logic [7:0]  ram_rdata,
    output logic        uart_tx
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam int          BW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int          BL        = BAUD_DIV - 1;
    localparam logic [BW-1:0] BAUD_LAST = BL[BW-1:0];
    localparam logic [19:0] IO_DATA   = IO_BASE + 20'd1;

    logic          w_is_stat;
    logic          w_is_data;
    logic          w_io_sel;
    logic          w_push;
    logic          w_clr;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic [7:0]    w_status;

    tx_state_t     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;
`ifdef CORE_BUS_PARITY_EN
    logic          r_par;
`endif

    // Address decode, FIFO handshake and read-data mux
    always_comb begin
        w_is_stat = (address == IO_BASE);
        w_is_data = (address == IO_DATA);
        w_io_sel  = w_is_stat | w_is_data;
        w_push    = wren & w_is_data;
        w_clr     = wren & w_is_stat;
        w_pop     = (r_state == ST_IDLE) && (w_count != {CW{1'b0}});
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
        w_drop    = w_push & w_full & ~w_pop;
        w_status  = 8'h00;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BUSY]  = (r_state != ST_IDLE);
        w_status[STAT_OVF]   = r_ovf;
        if (!w_io_sel) begin
            rdata = ram_rdata;
        end else if (w_is_stat) begin
            rdata = w_status;
        end else begin
            rdata = 8'h00;
        end
    end

    assign ram_address = address;
    assign ram_wdata   = wdata;
    assign ram_wren    = wren & ~w_io_sel;
    assign uart_tx     = r_tx;

    core_bus_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (wdata),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    // Sticky overflow flag, cleared by any write to the status address
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    // Transmitter FSM; r_tx is loaded with the level of the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
`ifdef CORE_BUS_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef CORE_BUS_PARITY_EN
                        r_par   <= even_parity(w_head);
`endif
                        r_baud  <= {BW{1'b0}};
                        r_bit   <= 3'd0;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= {BW{1'b0}};
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= {BW{1'b0}};
                        if (r_bit == 3'd7) begin
                            r_bit <= 3'd0;
`ifdef CORE_BUS_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
`ifdef CORE_BUS_PARITY_EN
                ST_PARITY: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= {BW{1'b0}};
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
`endif
                ST_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= {BW{1'b0}};
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus.sv
// Scoreboard bench for core_bus: accepted UART bytes are queued, a serial monitor
// decodes uart_tx frame by frame and compares against the queue.
module tb_core_bus;
    localparam int          BAUD    = 4;
    localparam int          DEPTH   = 16;
    localparam logic [19:0] IO_BASE = 20'hFFFF0;
    localparam logic [19:0] IO_DATA = 20'hFFFF1;
`ifdef CORE_BUS_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] address;
    logic [7:0]  wdata;
    logic        wren;
    logic [7:0]  rdata;
    logic [19:0] ram_address;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_rdata;
    logic        uart_tx;

    core_bus #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .wdata       (wdata),
        .wren        (wren),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_rdata   (ram_rdata),
        .uart_tx     (uart_tx)
    );

    always #5 clock = ~clock;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic       mon_busy = 1'b0;
    int         mon_gap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Serial frame for one byte, LSB at index 0 (start bit first)
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef CORE_BUS_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Serial monitor: every low level on an idle line starts a frame that must match the queue head
    initial begin : monitor
        int          idle_run;
        logic [7:0]  d;
        logic [10:0] f;
        logic [10:0] obs;
        bit          bad;
        bit          aborted;
        bit          unexp;
        idle_run = 0;
        forever begin
            @(negedge clock);
            if (reset || uart_tx !== 1'b0) begin
                idle_run++;
            end else begin
                mon_busy = 1'b1;
                mon_gap  = idle_run;
                obs      = 11'h7FF;
                bad      = 1'b0;
                aborted  = 1'b0;
                unexp    = (exp_q.size() == 0);
                d        = 8'h00;
                if (!unexp) d = exp_q.pop_front();
                f = frame_bits(d);
                for (int i = 0; i < NBITS * BAUD; i++) begin
                    if (i != 0) @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx !== f[i / BAUD]) bad = 1'b1;
                    if (i % BAUD == BAUD / 2) obs[i / BAUD] = uart_tx;
                end
                if (unexp) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got frame bits %b, expected no frame", obs);
                end else if (!aborted) begin
                    tests++;
                    if (bad) begin
                        fails++;
                        $display("FAIL frame: got bits %b, expected %b (byte %h)", obs, f, d);
                    end
                end
                idle_run = 0;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [19:0] a, input logic [7:0] d);
        address = a;
        wdata   = d;
        wren    = 1'b1;
        @(negedge clock);
        wren    = 1'b0;
        address = IO_BASE;
    endtask

    task automatic send(input logic [7:0] d);
        exp_q.push_back(d);
        bus_write(IO_DATA, d);
    endtask

    task automatic status_is(input string name, input logic [7:0] exp);
        address = IO_BASE;
        wren    = 1'b0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", n >= limit, 1'b0);
        repeat (4) @(negedge clock);
    endtask

    initial begin : stimulus
        logic [19:0] a;
        logic [7:0]  e;
        int          sel;
        int          lows;
        reset     = 1'b1;
        address   = 20'h00000;
        wdata     = 8'h00;
        wren      = 1'b0;
        ram_rdata = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        status_is("reset_status", 8'h02);
        check("reset_tx", uart_tx, 1'b1);

        // RAM pass-through at a fixed address
        address   = 20'h00100;
        ram_rdata = 8'h5A;
        #1;
        check("ram_rdata", rdata, 8'h5A);
        check("ram_wren_idle", ram_wren, 1'b0);
        wren  = 1'b1;
        wdata = 8'h33;
        #1;
        check("ram_wren", ram_wren, 1'b1);
        check("ram_wdata", ram_wdata, 8'h33);
        check("ram_address", ram_address, 20'h00100);
        @(negedge clock);
        wren = 1'b0;

        // Randomised reads/writes across RAM and the I/O window (no UART pushes)
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) a = IO_BASE;
            else if (sel == 1) a = IO_DATA;
            else begin
                a = 20'($urandom);
                if (a == IO_BASE || a == IO_DATA) a = 20'h00100;
            end
            address   = a;
            ram_rdata = 8'($urandom);
            wren      = (sel == 1) ? 1'b0 : 1'($urandom);
            #1;
            if (sel == 0) e = 8'h02;
            else if (sel == 1) e = 8'h00;
            else e = ram_rdata;
            check("rand_rdata", rdata, e);
            check("rand_ram_wren", ram_wren, (sel >= 2) ? wren : 1'b0);
            @(negedge clock);
        end
        wren = 1'b0;

        // Single frame 8'hA5 with first-bit latency
        send(8'hA5);
        status_is("status_after_push", 8'h00);
        check("tx_before_start", uart_tx, 1'b1);
        @(negedge clock);
        status_is("status_popped", 8'h06);
        check("tx_start", uart_tx, 1'b0);
        wait_drain(500);
        status_is("status_idle", 8'h02);

        // Overflow: transmitter busy, 16 writes fill the FIFO, the 17th is dropped
        send(8'($urandom));
        @(negedge clock);
        for (int k = 0; k < 17; k++) begin
            e = 8'($urandom);
            if (k < 16) exp_q.push_back(e);
            bus_write(IO_DATA, e);
        end
        status_is("status_overflow", 8'h0D);
        bus_write(IO_BASE, 8'h00);
        status_is("status_ovf_cleared", 8'h05);
        wait_drain(3000);
        status_is("status_after_drain", 8'h02);

        // Push while the FSM pops the last entry: both bytes sent, one idle cycle between
        send(8'h3C);
        send(8'hC3);
        status_is("status_push_pop", 8'h04);
        wait_drain(500);
        check("b2b_gap", mon_gap, 1);

        // Randomised bursts that never overflow
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) send(8'($urandom));
            repeat ($urandom_range(0, 60)) @(negedge clock);
        end
        wait_drain(2000);

        // Reset during data bit 3 aborts the frame
        send(8'hF7);
        repeat (17) @(negedge clock);
        check("mid_frame_bit3", uart_tx, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("reset_tx_high", uart_tx, 1'b1);
        status_is("reset_status_mid", 8'h02);
        @(negedge clock);
        reset = 1'b0;
        lows  = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_residual_frame", lows, 0);
        status_is("status_final", 8'h02);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
